// File: rtl/systolic_feed_ctrl.sv
// systolic_feed_ctrl
// Walks the instruction list and, for each instruction, streams pre-skewed
// operand columns from memA/memB into the 4x4 PE array. It then captures the
// results into output memory, clears the accumulators and moves to the next
// instruction. A one-cycle ap_done pulse marks the end of the list.

module systolic_feed_ctrl #(
   parameter int N_INSTR  = 8,
   parameter int PIPE_LAT = 2,
   parameter int COL_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ap_start,
   output logic             ap_done,
   output logic [4:0]       currInstruction,
   output logic [2:0]       addrI_rd,
   input  logic [4:0]       instI,
   output logic [COL_W-1:0] col_addr,
   output logic             col_rd,
   input  logic [63:0]      memA_q,
   input  logic [63:0]      memB_q,
   output logic [63:0]      arr_a,
   output logic [63:0]      arr_b,
   output logic             arr_valid,
   output logic             arr_clear,
   output logic             cap_en,
   output logic [6:0]       cap_base,
   output logic             overrun
);

   // The index must be able to reach N_INSTR itself, because that value
   // signals that the list ran to its full depth without a terminator.
   localparam int IDX_W = $clog2(N_INSTR + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INSTR);

   // The flush counter counts down from PIPE_LAT-1 to 0.
   localparam int FL_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
   localparam logic [FL_W-1:0] FLUSH_LAST = FL_W'(PIPE_LAT - 1);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      FWAIT,
      STREAM,
      FLUSH,
      CAPTURE,
      CLEAR,
      DONE
   } state_t;

   state_t           state;
   logic [IDX_W-1:0] index;
   logic [IDX_W-1:0] nextIndex;
   logic [COL_W-1:0] ptr;
   logic [5:0]       colsLeft;
   logic [FL_W-1:0]  flushCnt;
   logic             rdPipe;

   // addrI_rd and col_addr are taken straight from registers, so they are
   // glitch-free. Only the low three index bits address the 8-deep
   // instruction memory.
   assign addrI_rd  = index[2:0];
   assign col_addr  = ptr;
   assign nextIndex = index + 1'b1;

   // Main sequencer. The single-cycle pulses (ap_done, cap_en, arr_clear)
   // and cap_base default low and are raised only on the transition into the
   // state that owns them. Each pulse is therefore aligned with that state.
   // The column pointer runs freely across instructions. It is zeroed only
   // when a new run is accepted, so consecutive matrices in memory are read
   // back to back.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= IDLE;
         index           <= '0;
         ptr             <= '0;
         colsLeft        <= '0;
         flushCnt        <= '0;
         currInstruction <= '0;
         col_rd          <= 1'b0;
         cap_en          <= 1'b0;
         cap_base        <= '0;
         arr_clear       <= 1'b0;
         ap_done         <= 1'b0;
         overrun         <= 1'b0;
      end else begin
         cap_en    <= 1'b0;
         cap_base  <= '0;
         arr_clear <= 1'b0;
         ap_done   <= 1'b0;
         unique case (state)
            IDLE: begin
               if (ap_start) begin
                  state   <= FETCH;
                  index   <= '0;
                  ptr     <= '0;
                  overrun <= 1'b0;
               end
            end
            FETCH: begin
               state <= FWAIT;
            end
            FWAIT: begin
               if (instI == 5'd0) begin
                  state   <= DONE;
                  ap_done <= 1'b1;
               end else begin
                  currInstruction <= instI;
                  colsLeft        <= {1'b0, instI} + ((index == '0) ? 6'd5 : 6'd6);
                  col_rd          <= 1'b1;
                  state           <= STREAM;
               end
            end
            STREAM: begin
               ptr <= ptr + 1'b1;
               if (ptr == '1) begin
                  overrun <= 1'b1;
               end
               if (colsLeft == '0) begin
                  col_rd   <= 1'b0;
                  flushCnt <= FLUSH_LAST;
                  state    <= FLUSH;
               end else begin
                  colsLeft <= colsLeft - 1'b1;
               end
            end
            FLUSH: begin
               if (flushCnt == '0) begin
                  state    <= CAPTURE;
                  cap_en   <= 1'b1;
                  cap_base <= {index[2:0], 4'b0000};
               end else begin
                  flushCnt <= flushCnt - 1'b1;
               end
            end
            CAPTURE: begin
               state     <= CLEAR;
               arr_clear <= 1'b1;
            end
            CLEAR: begin
               index <= nextIndex;
               if (nextIndex == LAST_IDX) begin
                  state   <= DONE;
                  ap_done <= 1'b1;
               end else begin
                  state <= FETCH;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Operand path. The read strobe is delayed by one cycle to line up with
   // the memory output, then the lanes are registered into the array.
   // Lanes are forced to zero whenever no real column is present, so the
   // array never sees stale memory data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdPipe    <= 1'b0;
         arr_valid <= 1'b0;
         arr_a     <= '0;
         arr_b     <= '0;
      end else begin
         rdPipe    <= col_rd;
         arr_valid <= rdPipe;
         arr_a     <= rdPipe ? memA_q : '0;
         arr_b     <= rdPipe ? memB_q : '0;
      end
   end

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// tb_systolic_feed_ctrl
// Runs directed and random instruction lists through systolic_feed_ctrl.
// Every output is compared cycle by cycle against a timeline that is built
// arithmetically from each list.

module tb_systolic_feed_ctrl;

   localparam int PIPE_LAT = 2;
   localparam int MAXC     = 512;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ap_start = 1'b0;
   logic        ap_done;
   logic [4:0]  currInstruction;
   logic [2:0]  addrI_rd;
   logic [4:0]  instI;
   logic [7:0]  col_addr;
   logic        col_rd;
   logic [63:0] memA_q;
   logic [63:0] memB_q;
   logic [63:0] arr_a;
   logic [63:0] arr_b;
   logic        arr_valid;
   logic        arr_clear;
   logic        cap_en;
   logic [6:0]  cap_base;
   logic        overrun;

   logic [4:0]  imem [8];

   int totalChecks = 0;
   int badChecks   = 0;
   int curCycle    = 0;

   bit expRd       [MAXC];
   int expAddr     [MAXC];
   bit expCap      [MAXC];
   int expBase     [MAXC];
   bit expClr      [MAXC];
   bit expDone     [MAXC];
   int expCur      [MAXC];
   bit expOvr      [MAXC];
   bit expFetch    [MAXC];
   int expFetchIdx [MAXC];
   int doneCyc;
   int lastInstr  = 0;
   int modelInstr = 0;

   systolic_feed_ctrl dut (
      .clk             (clk),
      .rst             (rst),
      .ap_start        (ap_start),
      .ap_done         (ap_done),
      .currInstruction (currInstruction),
      .addrI_rd        (addrI_rd),
      .instI           (instI),
      .col_addr        (col_addr),
      .col_rd          (col_rd),
      .memA_q          (memA_q),
      .memB_q          (memB_q),
      .arr_a           (arr_a),
      .arr_b           (arr_b),
      .arr_valid       (arr_valid),
      .arr_clear       (arr_clear),
      .cap_en          (cap_en),
      .cap_base        (cap_base),
      .overrun         (overrun)
   );

   // Free-running 10-unit clock.
   initial begin
      forever #5 clk = ~clk;
   end

   // Known operand contents: A lane r holds 100r+col, B lane r holds
   // 1000+300r+col.
   function automatic logic [63:0] laneA(input int col);
      logic [63:0] v;
      for (int r = 0; r < 4; r++) v[16*r +: 16] = 16'(100*r + col);
      return v;
   endfunction

   function automatic logic [63:0] laneB(input int col);
      logic [63:0] v;
      for (int r = 0; r < 4; r++) v[16*r +: 16] = 16'(1000 + 300*r + col);
      return v;
   endfunction

   // Synchronous-read memories. Without a read strobe they return junk, so
   // any leak of unstrobed data into the array lanes is visible.
   always @(posedge clk) begin
      instI <= imem[addrI_rd];
      if (col_rd) begin
         memA_q <= laneA(int'(col_addr));
         memB_q <= laneB(int'(col_addr));
      end else begin
         memA_q <= {$urandom, $urandom};
         memB_q <= {$urandom, $urandom};
      end
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      totalChecks++;
      if (observed !== expected) begin
         badChecks++;
         $display("[TB] FAIL %s cycle=%0d got=%0h expected=%0h", tag, curCycle, observed, expected);
      end
   endtask

   task automatic loadList(input int a0, a1, a2, a3, a4, a5, a6, a7);
      imem[0] = 5'(a0); imem[1] = 5'(a1); imem[2] = 5'(a2); imem[3] = 5'(a3);
      imem[4] = 5'(a4); imem[5] = 5'(a5); imem[6] = 5'(a6); imem[7] = 5'(a7);
   endtask

   // Builds the expected per-cycle timeline from the list. Cycle 1 is the
   // first cycle after ap_start is accepted. Each instruction occupies 2
   // fetch cycles, L stream cycles, PIPE_LAT flush cycles, a capture cycle
   // and a clear cycle. A terminator costs fetch, wait and done. A full list
   // ends with a single done cycle.
   task automatic buildModel();
      int  t, ptr, x, len, cap, cur;
      bit  ovr;
      for (int i = 0; i < MAXC; i++) begin
         expRd[i] = 0; expAddr[i] = 0; expCap[i] = 0; expBase[i] = 0;
         expClr[i] = 0; expDone[i] = 0; expCur[i] = lastInstr; expOvr[i] = 0;
         expFetch[i] = 0; expFetchIdx[i] = 0;
      end
      t = 1; ptr = 0; cur = lastInstr; doneCyc = 0;
      for (int k = 0; k < 8; k++) begin
         expFetch[t] = 1;
         expFetchIdx[t] = k;
         x = int'(imem[k]);
         if (x == 0) begin
            doneCyc = t + 2;
            break;
         end
         len = (k == 0) ? x + 6 : x + 7;
         for (int j = 0; j < len; j++) begin
            expRd[t+2+j] = 1;
            expAddr[t+2+j] = ptr;
            ptr = (ptr + 1) % 256;
         end
         for (int i = t + 2; i < MAXC; i++) expCur[i] = x;
         cap = t + 2 + len + PIPE_LAT;
         expCap[cap] = 1;
         expBase[cap] = 16 * k;
         expClr[cap+1] = 1;
         t = cap + 2;
         cur = x;
      end
      if (doneCyc == 0) doneCyc = t;
      expDone[doneCyc] = 1;
      ovr = 0;
      for (int c = 1; c < MAXC; c++) begin
         expOvr[c] = ovr;
         if (expRd[c] && expAddr[c] == 255) ovr = 1;
      end
      modelInstr = cur;
   endtask

   task automatic checkCycle(input int c);
      logic [63:0] expA, expB;
      bit          v;
      curCycle = c;
      v = 1'b0; expA = '0; expB = '0;
      if (c >= 3) begin
         if (expRd[c-2]) begin
            v = 1'b1;
            expA = laneA(expAddr[c-2]);
            expB = laneB(expAddr[c-2]);
         end
      end
      checkOutput("col_rd", col_rd, expRd[c]);
      if (expRd[c]) checkOutput("col_addr", col_addr, expAddr[c]);
      checkOutput("arr_valid", arr_valid, v);
      checkOutput("arr_a", arr_a, expA);
      checkOutput("arr_b", arr_b, expB);
      checkOutput("cap_en", cap_en, expCap[c]);
      if (expCap[c]) checkOutput("cap_base", cap_base, expBase[c]);
      checkOutput("arr_clear", arr_clear, expClr[c]);
      checkOutput("ap_done", ap_done, expDone[c]);
      checkOutput("currInstruction", currInstruction, expCur[c]);
      checkOutput("overrun", overrun, expOvr[c]);
      if (expFetch[c]) checkOutput("addrI_rd", addrI_rd, expFetchIdx[c]);
   endtask

   task automatic checkAllZero(input string phase);
      checkOutput({phase, ".ap_done"}, ap_done, 0);
      checkOutput({phase, ".currInstruction"}, currInstruction, 0);
      checkOutput({phase, ".addrI_rd"}, addrI_rd, 0);
      checkOutput({phase, ".col_addr"}, col_addr, 0);
      checkOutput({phase, ".col_rd"}, col_rd, 0);
      checkOutput({phase, ".arr_a"}, arr_a, 0);
      checkOutput({phase, ".arr_b"}, arr_b, 0);
      checkOutput({phase, ".arr_valid"}, arr_valid, 0);
      checkOutput({phase, ".arr_clear"}, arr_clear, 0);
      checkOutput({phase, ".cap_en"}, cap_en, 0);
      checkOutput({phase, ".cap_base"}, cap_base, 0);
      checkOutput({phase, ".overrun"}, overrun, 0);
   endtask

   // One run of the list in imem. pokeAt pulses ap_start during the run:
   // 0 means never, a negative value or anything past done means the done
   // cycle. abortAt, if nonzero, asserts reset in that cycle and ends the run.
   task automatic applyStimulus(input int pokeAt, input int abortAt);
      int poke;
      buildModel();
      poke = (pokeAt < 0 || pokeAt > doneCyc) ? doneCyc : pokeAt;
      @(negedge clk);
      ap_start = 1'b1;
      @(negedge clk);
      for (int c = 1; c <= doneCyc + 2; c++) begin
         ap_start = (c == poke);
         checkCycle(c);
         if (c == abortAt) begin
            ap_start = 1'b0;
            rst = 1'b1;
            #1;
            checkAllZero("abort");
            @(negedge clk);
            rst = 1'b0;
            lastInstr = 0;
            return;
         end
         @(negedge clk);
      end
      ap_start = 1'b0;
      lastInstr = modelInstr;
   endtask

   initial begin
      loadList(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) @(negedge clk);
      checkAllZero("reset");
      rst = 1'b0;
      @(negedge clk);

      $display("[TB] single instruction list");
      loadList(2, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(5, 0);

      $display("[TB] two instructions, start poked on done");
      loadList(1, 3, 0, 0, 0, 0, 0, 0);
      applyStimulus(-1, 0);

      $display("[TB] empty list");
      loadList(0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(2, 0);

      $display("[TB] full list with pointer wrap");
      loadList(31, 31, 31, 31, 31, 31, 31, 31);
      applyStimulus(100, 0);

      $display("[TB] restart clears overrun");
      loadList(4, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0);

      $display("[TB] reset during streaming");
      loadList(31, 31, 0, 0, 0, 0, 0, 0);
      applyStimulus(5, 10);
      loadList(5, 9, 0, 0, 0, 0, 0, 0);
      applyStimulus(20, 0);

      $display("[TB] random lists");
      repeat (14) begin
         for (int k = 0; k < 8; k++) begin
            imem[k] = ($urandom_range(0, 6) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         end
         applyStimulus(int'($urandom_range(0, 60)), 0);
      end

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule

// File: doc/systolic_feed_ctrl.md
Name: systolic_feed_ctrl

Overview:
- Sequencer between the instruction/operand memories and the 4x4 systolic PE array inside top.
- On ap_start it walks the instruction list. For each instruction it streams the pre-skewed operand columns of memA/memB into the array, then triggers result capture into output memory and clears the accumulators.
- Asserts ap_done when the list ends.
- Operand memories are banked as 4 rows x 256 columns, 16-bit. Output memory holds 16 words per instruction.

Parameters:
- N_INSTR, 8, instruction memory depth; list ends at first 0 or after N_INSTR entries.
- PIPE_LAT, 2, cycles from last column issue until that column has entered the array.
- COL_W, 8, column pointer width (256 columns per row bank).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- ap_start  in  1  start request, sampled only in IDLE.
- ap_done  out  1  one-cycle completion pulse.
- currInstruction  out  5  instruction value currently being executed.
- addrI_rd  out  3  instruction memory read address (sync read, 1-cycle latency).
- instI  in  5  instruction memory read data.
- col_addr  out  COL_W  column read address, applied to all 4 rows of memA and memB.
- col_rd  out  1  column read strobe.
- memA_q  in  64  4 lanes x 16 bit from memA, valid 1 cycle after col_rd; lane r = bits 16r+15:16r.
- memB_q  in  64  same layout, from memB.
- arr_a  out  64  A lanes to array row inputs (registered from memA_q).
- arr_b  out  64  B lanes to array column inputs (registered from memB_q).
- arr_valid  out  1  arr_a/arr_b carry a real column this cycle.
- arr_clear  out  1  one-cycle accumulator clear.
- cap_en  out  1  one-cycle pulse: output writer stores 16 PE results.
- cap_base  out  7  output memory base for the capture, = 16 x instruction index.
- overrun  out  1  sticky: column pointer wrapped past 255; cleared on accepted ap_start.

Behaviour:
- Reset values: all outputs 0, col pointer 0, index 0, state IDLE. Asynchronous reset mid-operation aborts immediately; no ap_done is produced.
- States: IDLE, FETCH, FWAIT, STREAM, FLUSH, CAPTURE, CLEAR, DONE.
- IDLE:
  - ap_start=1 moves to FETCH.
  - Index, col pointer and overrun are zeroed on entry to FETCH.
  - ap_start outside IDLE is ignored.
- FETCH: drive addrI_rd=index, for 1 cycle, then go to FWAIT.
- FWAIT: instI is valid.
  - If instI==0, go to DONE.
  - Else latch x=instI into currInstruction.
  - Column count L = x+6 for index 0, x+7 otherwise; the extra column is the inter-matrix spacer already present in memory.
  - Go to STREAM.
- STREAM:
  - Each cycle: col_rd=1, col_addr=pointer, pointer+1, remaining L-1.
  - Exactly L cycles, then go to FLUSH.
  - Pointer is never reset between instructions.
- Data path:
  - arr_a/arr_b/arr_valid are the col_rd-delayed memory outputs, 2 cycles after the issuing col_rd.
  - arr_a/arr_b are 0 whenever arr_valid=0.
- FLUSH: PIPE_LAT cycles, no col_rd; then go to CAPTURE.
- CAPTURE: cap_en=1 and cap_base=index<<4 for 1 cycle; then go to CLEAR.
- CLEAR:
  - arr_clear=1 for 1 cycle; index+1.
  - If the new index==N_INSTR, go to DONE; else go to FETCH.
- DONE: ap_done=1 for 1 cycle; currInstruction is held; then go to IDLE.
- Wrap-around: pointer increment from 255 goes to 0 and sets overrun. Streaming continues; no stall.
- currInstruction resets to 0; otherwise it holds its last value until the next FWAIT latch.
- ap_start asserted in the same cycle ap_done pulses is ignored, because the state is DONE, not IDLE.

Test Plan:
- List [2,0,...], ap_start one cycle:
  - 8 col_rd cycles, col_addr 0..7.
  - arr_valid 8 cycles.
  - Then 2 flush cycles, cap_en with cap_base=0, arr_clear.
  - One more FETCH/FWAIT, then ap_done.
  - currInstruction=2 throughout.
- List [1,3,0]:
  - First stream columns 0..6 (7 columns), cap_base=0.
  - Second stream columns 7..16 (10 columns), cap_base=16.
  - One ap_done, overrun=0.
- List [0,...]: ap_done 3 cycles after start (FETCH, FWAIT, DONE), with no col_rd, cap_en or arr_clear.
- Eight instructions of 31 with no terminator:
  - 8 captures, cap_base 0,16..112, then ap_done without fetching index 8.
  - Total columns 37+7x38=303, so pointer wraps and overrun=1.
  - Next ap_start clears overrun.
- Memory model returns known lane values (A lane r = 100r+col):
  - arr_a lane r equals 100r+col exactly 2 cycles after the matching col_rd.
  - arr_a=0 when arr_valid=0.
- Reset asserted mid-STREAM:
  - All outputs 0 immediately and state IDLE.
  - A later ap_start restarts from col 0 and index 0, and completes normally.
  - ap_start pulsed during STREAM has no effect.
